// File: rtl/bp_pkg.sv
// Sizing, FSM state and update-queue entry type shared by the branch predictor table scheduler.
// Optional macro BP_STATS_EN adds the mispredict bit to the queue entry.
package bp_pkg;
  localparam int ENTRIES = 22;
  localparam int IDX_W   = 5;
  localparam int HIST_W  = 3;
  localparam int QDEPTH  = 4;
  localparam int QPTR_W  = $clog2(QDEPTH);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} bp_state_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
`ifdef BP_STATS_EN
    logic             mispred;
`endif
  } bp_update_t;

  // Two-bit saturating counter step toward the resolved outcome.
  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken && cnt != 2'd3) res = cnt + 2'd1;
    else if (!taken && cnt != 2'd0) res = cnt - 2'd1;
    return res;
  endfunction
endpackage

// File: rtl/bp_update_fifo.sv
// Circular buffer of pending predictor updates; pointers carry one extra wrap bit
// so full and empty are told apart without an occupancy counter.
module bp_update_fifo
  import bp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  bp_update_t din,
  output bp_update_t dout,
  output logic       full,
  output logic       empty
);
  localparam logic [QPTR_W:0] PTR_ONE = (QPTR_W + 1)'(1);

  bp_update_t      mem [QDEPTH];
  logic [QPTR_W:0] wr_ptr;
  logic [QPTR_W:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[QPTR_W] != rd_ptr[QPTR_W]) &&
                 (wr_ptr[QPTR_W-1:0] == rd_ptr[QPTR_W-1:0]);
  assign dout  = mem[rd_ptr[QPTR_W-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[QPTR_W-1:0]] <= din;
  end
endmodule

// File: rtl/bp_table_scheduler.sv
// Clears the predictor table after reset, then shares its single read port between lookups
// and queued read-modify-write updates. Optional macro BP_STATS_EN adds update/mispredict counters.
module bp_table_scheduler
  import bp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              lookup_valid,
  input  logic [IDX_W-1:0]  lookup_idx,
  output logic              lookup_ready,
  output logic              pred_taken,
  input  logic              update_valid,
  input  logic [IDX_W-1:0]  update_idx,
  input  logic              update_taken,
  input  logic              update_mispred,
  output logic              update_ready,
  output logic [IDX_W-1:0]  tbl_ridx,
  input  logic [1:0]        tbl_rcounter,
  input  logic [HIST_W-1:0] tbl_rhist,
  output logic              tbl_we,
  output logic [IDX_W-1:0]  tbl_widx,
  output logic [1:0]        tbl_wcounter,
  output logic [HIST_W-1:0] tbl_whist,
  output logic              init_done,
  output bp_state_t         dbg_state
`ifdef BP_STATS_EN
  ,
  output logic [15:0]       stat_updates,
  output logic [15:0]       stat_mispred
`endif
);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] SWEEP_END = IDX_W'(ENTRIES - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready; ready never depends
  // on valid, and a lookup's pred_taken is only meaningful in its transfer cycle.
  bp_state_t        state;
  bp_state_t        next_state;
  logic [IDX_W-1:0] sweep;
  bp_update_t       upd_in;
  bp_update_t       head;
  logic             q_full;
  logic             q_empty;
  logic             push;
  logic             drain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= INIT;
      sweep <= '0;
    end else begin
      state <= next_state;
      if (state == INIT) sweep <= sweep + IDX_ONE;
    end
  end

  always_comb begin
    next_state   = state;
    lookup_ready = 1'b0;
    update_ready = 1'b0;
    drain        = 1'b0;
    tbl_ridx     = lookup_idx;
    tbl_we       = 1'b0;
    tbl_widx     = sweep;
    tbl_wcounter = '0;
    tbl_whist    = '0;
    case (state)
      INIT: begin
        tbl_we = 1'b1;
        if (sweep == SWEEP_END) next_state = RUN;
      end
      RUN: begin
        update_ready = !q_full;
        lookup_ready = !q_full;
        // A full queue always drains so lookups cannot starve updates indefinitely.
        drain = q_full || (!lookup_valid && !q_empty);
        if (drain) begin
          tbl_ridx     = head.idx;
          tbl_we       = 1'b1;
          tbl_widx     = head.idx;
          tbl_wcounter = sat_step(tbl_rcounter, head.taken);
          tbl_whist    = {tbl_rhist[HIST_W-2:0], head.taken};
        end
      end
      default: next_state = INIT;
    endcase
  end

  assign pred_taken = lookup_valid && lookup_ready && tbl_rcounter[1];
  assign push       = update_valid && update_ready;
  assign init_done  = (state == RUN);
  assign dbg_state  = state;

  always_comb begin
    upd_in       = '0;
    upd_in.idx   = update_idx;
    upd_in.taken = update_taken;
`ifdef BP_STATS_EN
    upd_in.mispred = update_mispred;
`endif
  end

  bp_update_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (drain),
    .din   (upd_in),
    .dout  (head),
    .full  (q_full),
    .empty (q_empty)
  );

`ifdef BP_STATS_EN
  logic unused_hist_msb;
  assign unused_hist_msb = tbl_rhist[HIST_W-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_updates <= '0;
      stat_mispred <= '0;
    end else if (drain) begin
      if (stat_updates != 16'hFFFF) stat_updates <= stat_updates + 16'd1;
      if (head.mispred && stat_mispred != 16'hFFFF) stat_mispred <= stat_mispred + 16'd1;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{update_mispred, tbl_rhist[HIST_W-1]};
`endif
endmodule

// File: tb/tb_bp_table_scheduler.sv
// Self-checking bench for bp_table_scheduler: table storage model, reference predictor model
// feeding an expected-write queue, directed scenarios and a random phase.
module tb_bp_table_scheduler;
  import bp_pkg::*;

  localparam int W = IDX_W + 2 + HIST_W;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              lookup_valid = 1'b0;
  logic [IDX_W-1:0]  lookup_idx = '0;
  logic              lookup_ready;
  logic              pred_taken;
  logic              update_valid = 1'b0;
  logic [IDX_W-1:0]  update_idx = '0;
  logic              update_taken = 1'b0;
  logic              update_mispred = 1'b0;
  logic              update_ready;
  logic [IDX_W-1:0]  tbl_ridx;
  logic [1:0]        tbl_rcounter;
  logic [HIST_W-1:0] tbl_rhist;
  logic              tbl_we;
  logic [IDX_W-1:0]  tbl_widx;
  logic [1:0]        tbl_wcounter;
  logic [HIST_W-1:0] tbl_whist;
  logic              init_done;
  bp_state_t         dbg_state;
`ifdef BP_STATS_EN
  logic [15:0]       stat_updates;
  logic [15:0]       stat_mispred;
`endif

  bp_table_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .lookup_valid   (lookup_valid),
    .lookup_idx     (lookup_idx),
    .lookup_ready   (lookup_ready),
    .pred_taken     (pred_taken),
    .update_valid   (update_valid),
    .update_idx     (update_idx),
    .update_taken   (update_taken),
    .update_mispred (update_mispred),
    .update_ready   (update_ready),
    .tbl_ridx       (tbl_ridx),
    .tbl_rcounter   (tbl_rcounter),
    .tbl_rhist      (tbl_rhist),
    .tbl_we         (tbl_we),
    .tbl_widx       (tbl_widx),
    .tbl_wcounter   (tbl_wcounter),
    .tbl_whist      (tbl_whist),
    .init_done      (init_done),
    .dbg_state      (dbg_state)
`ifdef BP_STATS_EN
    ,
    .stat_updates   (stat_updates),
    .stat_mispred   (stat_mispred)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- table storage (starts non-zero so the sweep matters) ----------------
  logic [1:0]        mem_cnt  [32] = '{default: 2'd3};
  logic [HIST_W-1:0] mem_hist [32] = '{default: 3'b101};
  assign tbl_rcounter = mem_cnt[tbl_ridx];
  assign tbl_rhist    = mem_hist[tbl_ridx];
  always @(posedge clk) begin
    if (tbl_we) begin
      mem_cnt[tbl_widx]  <= tbl_wcounter;
      mem_hist[tbl_widx] <= tbl_whist;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0]      exp_q[$];
  logic [1:0]        ref_cnt  [ENTRIES];
  logic [HIST_W-1:0] ref_hist [ENTRIES];
  int n_cmp = 0;
  int n_err = 0;
  int run_we_cnt = 0;
  int exp_upd = 0;
  int exp_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_cnt(input logic [1:0] c, input logic t);
    if (t) return (c == 2'd3) ? c : c + 2'd1;
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  // Monitor: arbitration rules, write data against reference, push capture.
  always @(negedge clk) begin
    int occ;
    int ix;
    logic [W-1:0] e;
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < ENTRIES; i++) begin
        ref_cnt[i]  = 2'd0;
        ref_hist[i] = '0;
      end
      exp_upd = 0;
      exp_mis = 0;
    end else if (init_done) begin
      occ = exp_q.size();
      if (tbl_we) run_we_cnt++;
      check("update_ready", update_ready, occ < QDEPTH);
      if (occ == QDEPTH) begin
        check("full_lookup_ready", lookup_ready, 0);
        check("full_drain_we", tbl_we, 1);
      end else if (lookup_valid) begin
        check("lookup_grant", lookup_ready, 1);
        check("lookup_we", tbl_we, 0);
        check("pred_taken", pred_taken, mem_cnt[lookup_idx][1]);
      end else begin
        check("idle_drain_we", tbl_we, occ != 0);
      end
      if (tbl_we && occ != 0) begin
        e = exp_q.pop_front();
        check("write", {tbl_widx, tbl_wcounter, tbl_whist}, e);
      end
      if (update_valid && update_ready) begin
        ix = int'(update_idx);
        ref_cnt[ix]  = model_cnt(ref_cnt[ix], update_taken);
        ref_hist[ix] = {ref_hist[ix][HIST_W-2:0], update_taken};
        exp_q.push_back({update_idx, ref_cnt[ix], ref_hist[ix]});
        exp_upd++;
        if (update_mispred) exp_mis++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic push_update(input logic [IDX_W-1:0] idx, input logic t, input logic m);
    int n;
    update_valid   = 1'b1;
    update_idx     = idx;
    update_taken   = t;
    update_mispred = m;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!update_ready && n < 20);
    if (!update_ready) check("push_timeout", update_ready, 1);
    @(posedge clk);
    #1;
    update_valid = 1'b0;
  endtask

  // Starts just after reset release; checks every sweep write and the init_done rise.
  task automatic sweep_check();
    for (int i = 0; i < ENTRIES; i++) begin
      @(negedge clk);
      check("sweep_we", tbl_we, 1);
      check("sweep_widx", tbl_widx, i);
      check("sweep_wdata", {tbl_wcounter, tbl_whist}, 0);
      check("init_no_ready", {init_done, lookup_ready, update_ready}, 0);
    end
    @(negedge clk);
    check("init_done", init_done, 1);
    check("state_run", dbg_state, RUN);
  endtask

  // ---------------- stimulus ----------------
  int base;

  initial begin
    // reset values
    @(negedge clk);
    check("rst_init_done", init_done, 0);
    check("rst_lookup_ready", lookup_ready, 0);
    check("rst_update_ready", update_ready, 0);
    check("rst_pred_taken", pred_taken, 0);
    check("rst_tbl_we", tbl_we, 1);
    check("rst_tbl_widx", tbl_widx, 0);
    check("rst_tbl_wdata", {tbl_wcounter, tbl_whist}, 0);
    check("rst_state", dbg_state, INIT);
`ifdef BP_STATS_EN
    check("rst_stats", {stat_updates, stat_mispred}, 0);
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sweep_check();

    // idx 3 taken four times, no lookups
    @(posedge clk);
    #1;
    repeat (4) push_update(5'd3, 1'b1, 1'b0);
    idle_wait(6);
    check("t2_pending", exp_q.size(), 0);
    check("t2_cnt", mem_cnt[3], 2'd3);
    check("t2_hist", mem_hist[3], 3'b111);
    lookup_valid = 1'b1;
    lookup_idx   = 5'd3;
    @(negedge clk);
    check("t2_pred", pred_taken, 1);
    check("t2_ready", lookup_ready, 1);
    @(posedge clk);
    #1;

    // continuous lookups: updates wait until the queue is full
    lookup_idx = 5'd5;
    base = run_we_cnt;
    push_update(5'd5, 1'b1, 1'b0);
    push_update(5'd7, 1'b0, 1'b1);
    push_update(5'd5, 1'b1, 1'b0);
    push_update(5'd12, 1'b1, 1'b1);
    check("t3_no_early_drain", run_we_cnt - base, 0);
    @(negedge clk);
    check("t3_lookup_blocked", lookup_ready, 0);
    check("t3_update_blocked", update_ready, 0);
    check("t3_drain", {tbl_we, tbl_widx, tbl_wcounter, tbl_whist}, {1'b1, 5'd5, 2'd1, 3'b001});
    @(posedge clk);
    #1 lookup_valid = 1'b0;
    idle_wait(6);
    check("t3_pending", exp_q.size(), 0);

    // saturation at zero
    push_update(5'd10, 1'b1, 1'b0);
    push_update(5'd10, 1'b0, 1'b0);
    push_update(5'd10, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_sat_zero", {tbl_we, tbl_widx, tbl_wcounter, tbl_whist}, {1'b1, 5'd10, 2'd0, 3'b100});
    @(posedge clk);
    #1;
    idle_wait(4);

    // random traffic
    for (int c = 0; c < 300; c++) begin
      lookup_valid   = ($urandom_range(9, 0) < 6);
      lookup_idx     = IDX_W'($urandom_range(ENTRIES - 1, 0));
      update_valid   = $urandom_range(1, 0) == 1;
      update_idx     = IDX_W'($urandom_range(ENTRIES - 1, 0));
      update_taken   = $urandom_range(1, 0) == 1;
      update_mispred = $urandom_range(1, 0) == 1;
      @(posedge clk);
      #1;
    end
    lookup_valid = 1'b0;
    update_valid = 1'b0;
    idle_wait(8);
    check("t5_pending", exp_q.size(), 0);
`ifdef BP_STATS_EN
    check("t5_stat_updates", stat_updates, exp_upd);
    check("t5_stat_mispred", stat_mispred, exp_mis);
`endif

    // reset with three updates queued
    lookup_valid = 1'b1;
    lookup_idx   = 5'd2;
    push_update(5'd4, 1'b1, 1'b0);
    push_update(5'd6, 1'b1, 1'b0);
    push_update(5'd8, 1'b0, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_we", tbl_we, 1);
    check("t6_rst_widx", tbl_widx, 0);
    check("t6_rst_ready", {init_done, lookup_ready, update_ready}, 0);
    lookup_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sweep_check();
    base = run_we_cnt;
    idle_wait(8);
    check("t6_no_stale_writes", run_we_cnt - base, 0);
`ifdef BP_STATS_EN
    check("t6_stats_cleared", {stat_updates, stat_mispred}, 0);
`endif

    // five updates, two mispredicted
    push_update(5'd1, 1'b1, 1'b1);
    push_update(5'd2, 1'b0, 1'b0);
    push_update(5'd1, 1'b1, 1'b1);
    push_update(5'd20, 1'b1, 1'b0);
    push_update(5'd21, 1'b0, 1'b0);
    idle_wait(8);
    check("t7_pending", exp_q.size(), 0);
    check("t7_cnt1", mem_cnt[1], 2'd2);
    check("t7_hist1", mem_hist[1], 3'b011);
`ifdef BP_STATS_EN
    check("t7_stat_updates", stat_updates, 16'd5);
    check("t7_stat_mispred", stat_mispred, 16'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
